// File: rtl/pkt_sync_fifo_if.sv
// Purpose: write/read bundle of the store-and-forward packet FIFO.
// Latency: none; wires only.
// Backpressure: carries wr_full/almost_full upstream and rd_valid/rd_en downstream.
interface pkt_sync_fifo_if #(
   parameter int c_DATA_WIDTH  = 32,
   parameter int c_DEPTH_WIDTH = 10
);
   // write side
   logic [c_DATA_WIDTH-1:0]  wr_data;
   logic                     wr_en;
   logic                     wr_last;
   logic                     wr_drop;
   logic                     wr_full;
   logic                     almost_full;
   logic [c_DEPTH_WIDTH:0]   wr_water_level;
   logic                     wr_ovf_drop;
   // read side
   logic [c_DATA_WIDTH-1:0]  rd_data;
   logic                     rd_last;
   logic                     rd_valid;
   logic                     rd_en;
   logic                     rd_empty;
   logic                     almost_empty;
   logic [c_DEPTH_WIDTH:0]   rd_water_level;
   logic [c_DEPTH_WIDTH:0]   pkt_cnt;

   // producer/consumer side (drives writes and pops)
   modport master (
      output wr_data, wr_en, wr_last, wr_drop, rd_en,
      input  wr_full, almost_full, wr_water_level, wr_ovf_drop,
      input  rd_data, rd_last, rd_valid, rd_empty, almost_empty,
      input  rd_water_level, pkt_cnt
   );

   // FIFO side
   modport slave (
      input  wr_data, wr_en, wr_last, wr_drop, rd_en,
      output wr_full, almost_full, wr_water_level, wr_ovf_drop,
      output rd_data, rd_last, rd_valid, rd_empty, almost_empty,
      output rd_water_level, pkt_cnt
   );
endinterface

// File: rtl/pkt_sync_fifo.sv
// Purpose: single-clock store-and-forward packet FIFO with commit/drop and FWFT reads.
// Latency: commit edge to rd_valid is two cycles from empty; back-to-back pops at 1 word/clk.
// Backpressure: writes are never stalled (full frames are dropped); read word holds until rd_en.
module pkt_sync_fifo #(
   parameter int c_DATA_WIDTH       = 32,
   parameter int c_DEPTH_WIDTH      = 10,
   parameter int c_ALMOST_FULL_NUM  = 1016,
   parameter int c_ALMOST_EMPTY_NUM = 4
) (
   input  logic             clk,
   input  logic             rst,
   pkt_sync_fifo_if.slave   fifo_if
);

   localparam int                   c_DEPTH_WORDS = 1 << c_DEPTH_WIDTH;
   localparam logic [c_DEPTH_WIDTH:0] c_DEPTH     = {1'b1, {c_DEPTH_WIDTH{1'b0}}};
   localparam logic [c_DEPTH_WIDTH:0] c_PTR_ONE   = {{c_DEPTH_WIDTH{1'b0}}, 1'b1};
   localparam logic [c_DEPTH_WIDTH:0] c_AF_LVL    = c_ALMOST_FULL_NUM[c_DEPTH_WIDTH:0];
   localparam logic [c_DEPTH_WIDTH:0] c_AE_LVL    = c_ALMOST_EMPTY_NUM[c_DEPTH_WIDTH:0];

   // write FSM encoding
   localparam logic [0:0] ST_ACCEPT = 1'b0;
   localparam logic [0:0] ST_OVF    = 1'b1;

   // storage: payload plus last flag in the MSB
   logic [c_DATA_WIDTH:0]    mem [0:c_DEPTH_WORDS-1];

   logic [c_DEPTH_WIDTH:0]   wr_ptr;
   logic [c_DEPTH_WIDTH:0]   cm_ptr;
   logic [c_DEPTH_WIDTH:0]   pf_ptr;
   logic [c_DEPTH_WIDTH:0]   rd_ptr;
   logic [c_DEPTH_WIDTH:0]   pkt_cnt;
   logic [0:0]               wr_state;
   logic [0:0]               wr_state_nxt;
   logic                     ovf_drop_q;

   // write-side decode
   logic                     mem_we;
   logic                     commit;
   logic                     rewind;
   logic                     ovf_pulse;

   // read pipeline: stage 1 is the RAM output, stage 2 the FWFT output register
   logic [c_DATA_WIDTH:0]    s1_dat;
   logic                     s1_vld;
   logic [c_DATA_WIDTH:0]    out_dat;
   logic                     out_vld;
   logic                     pop;
   logic                     out_load;
   logic                     issue;

   logic [c_DEPTH_WIDTH:0]   wr_level;
   logic [c_DEPTH_WIDTH:0]   rd_level;
   logic                     full;

   assign wr_level = wr_ptr - rd_ptr;
   assign rd_level = cm_ptr - rd_ptr;
   assign full     = (wr_level == c_DEPTH);

   // Write FSM decode: drop wins, a full FIFO poisons the frame until its last word.
   always_comb begin
      mem_we       = 1'b0;
      commit       = 1'b0;
      rewind       = 1'b0;
      ovf_pulse    = 1'b0;
      wr_state_nxt = wr_state;
      if (fifo_if.wr_drop) begin
         rewind       = 1'b1;
         wr_state_nxt = ST_ACCEPT;
      end else if (wr_state == ST_ACCEPT) begin
         if (fifo_if.wr_en) begin
            if (!full) begin
               mem_we = 1'b1;
               commit = fifo_if.wr_last;
            end else if (fifo_if.wr_last) begin
               // overflow on the final word: discard the frame right away
               rewind    = 1'b1;
               ovf_pulse = 1'b1;
            end else begin
               wr_state_nxt = ST_OVF;
            end
         end
      end else if (fifo_if.wr_en && fifo_if.wr_last) begin
         rewind       = 1'b1;
         ovf_pulse    = 1'b1;
         wr_state_nxt = ST_ACCEPT;
      end
   end

   // Write pointers, commit pointer and FSM state.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         cm_ptr     <= '0;
         wr_state   <= ST_ACCEPT;
         ovf_drop_q <= 1'b0;
      end else begin
         wr_state   <= wr_state_nxt;
         ovf_drop_q <= ovf_pulse;
         if (rewind) begin
            wr_ptr <= cm_ptr;
         end else if (mem_we) begin
            wr_ptr <= wr_ptr + c_PTR_ONE;
         end
         if (commit) begin
            cm_ptr <= wr_ptr + c_PTR_ONE;
         end
      end
   end

   // RAM write port.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_ptr[c_DEPTH_WIDTH-1:0]] <= {fifo_if.wr_last, fifo_if.wr_data};
      end
   end

   // Read-side handshake: only committed words are fetched, and a word is
   // fetched only when the pipeline has room for it downstream.
   assign pop      = fifo_if.rd_en & out_vld;
   assign out_load = s1_vld & (~out_vld | pop);
   assign issue    = (cm_ptr != pf_ptr) & (~s1_vld | out_load);

   // RAM read port; synchronous, enabled only when a fetch is issued.
   always_ff @(posedge clk) begin
      if (issue) begin
         s1_dat <= mem[pf_ptr[c_DEPTH_WIDTH-1:0]];
      end
   end

   // Prefetch pointer and stage-1 valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         pf_ptr <= '0;
         s1_vld <= 1'b0;
      end else if (issue) begin
         pf_ptr <= pf_ptr + c_PTR_ONE;
         s1_vld <= 1'b1;
      end else if (out_load) begin
         s1_vld <= 1'b0;
      end
   end

   // FWFT output register: refilled from stage 1, emptied by a pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_dat <= '0;
         out_vld <= 1'b0;
      end else if (out_load) begin
         out_dat <= s1_dat;
         out_vld <= 1'b1;
      end else if (pop) begin
         out_vld <= 1'b0;
      end
   end

   // Popped pointer and frame count; commit and final-word pop cancel out.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr  <= '0;
         pkt_cnt <= '0;
      end else begin
         if (pop) begin
            rd_ptr <= rd_ptr + c_PTR_ONE;
         end
         case ({commit, pop & out_dat[c_DATA_WIDTH]})
            2'b10:   pkt_cnt <= pkt_cnt + c_PTR_ONE;
            2'b01:   pkt_cnt <= pkt_cnt - c_PTR_ONE;
            default: pkt_cnt <= pkt_cnt;
         endcase
      end
   end

   assign fifo_if.wr_full        = full;
   assign fifo_if.almost_full    = (wr_level >= c_AF_LVL);
   assign fifo_if.wr_water_level = wr_level;
   assign fifo_if.wr_ovf_drop    = ovf_drop_q;
   assign fifo_if.rd_data        = out_dat[c_DATA_WIDTH-1:0];
   assign fifo_if.rd_last        = out_dat[c_DATA_WIDTH];
   assign fifo_if.rd_valid       = out_vld;
   assign fifo_if.rd_empty       = ~out_vld;
   assign fifo_if.almost_empty   = (rd_level <= c_AE_LVL);
   assign fifo_if.rd_water_level = rd_level;
   assign fifo_if.pkt_cnt        = pkt_cnt;

endmodule

// File: tb/tb_pkt_sync_fifo.sv
// Purpose: directed self-checking bench for pkt_sync_fifo at depth 16.
// Latency: checks sample #1 after each rising edge.
// Backpressure: bench drives rd_en explicitly per cycle.
module tb_pkt_sync_fifo;

   localparam int DW = 16;
   localparam int AW = 4;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;
   int   lens [3];
   int   k;
   int   exp_lvl;

   pkt_sync_fifo_if #(.c_DATA_WIDTH(DW), .c_DEPTH_WIDTH(AW)) bus ();

   pkt_sync_fifo #(
      .c_DATA_WIDTH       (DW),
      .c_DEPTH_WIDTH      (AW),
      .c_ALMOST_FULL_NUM  (14),
      .c_ALMOST_EMPTY_NUM (2)
   ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .fifo_if (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_idle();
      bus.wr_en   = 1'b0;
      bus.wr_last = 1'b0;
      bus.wr_drop = 1'b0;
   endtask

   task automatic wr_word(input logic [DW-1:0] d, input bit last);
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      bus.wr_last = last;
      cyc();
   endtask

   // check the FWFT word, then pop it on the next edge (rd_en left high)
   task automatic pop_chk(input string tag, input logic [DW-1:0] d, input bit last);
      chk({tag, "_vld"},  32'(bus.rd_valid), 1);
      chk({tag, "_dat"},  32'(bus.rd_data),  32'(d));
      chk({tag, "_last"}, 32'(bus.rd_last),  32'(last));
      bus.rd_en = 1'b1;
      cyc();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_full"},  32'(bus.wr_full),        0);
      chk({tag, "_af"},    32'(bus.almost_full),    0);
      chk({tag, "_ovf"},   32'(bus.wr_ovf_drop),    0);
      chk({tag, "_vld"},   32'(bus.rd_valid),       0);
      chk({tag, "_empty"}, 32'(bus.rd_empty),       1);
      chk({tag, "_ae"},    32'(bus.almost_empty),   1);
      chk({tag, "_dat"},   32'(bus.rd_data),        0);
      chk({tag, "_last"},  32'(bus.rd_last),        0);
      chk({tag, "_pkt"},   32'(bus.pkt_cnt),        0);
      chk({tag, "_wlvl"},  32'(bus.wr_water_level), 0);
      chk({tag, "_rlvl"},  32'(bus.rd_water_level), 0);
   endtask

   initial begin
      n_chk       = 0;
      n_err       = 0;
      rst         = 1'b1;
      bus.wr_data = '0;
      bus.rd_en   = 1'b0;
      wr_idle();
      repeat (3) cyc();
      rst = 1'b0;
      cyc();
      chk_reset_vals("rst");

      // 4-word frame, commit only on the last word, FWFT two edges later
      for (int i = 0; i < 4; i++) begin
         wr_word(16'(16'h100 + i), i == 3);
         chk("t1_wlvl", 32'(bus.wr_water_level), i + 1);
         chk("t1_rlvl", 32'(bus.rd_water_level), (i == 3) ? 4 : 0);
      end
      wr_idle();
      chk("t1_vld_n0", 32'(bus.rd_valid), 0);
      cyc();
      chk("t1_vld_n1", 32'(bus.rd_valid), 0);
      cyc();
      chk("t1_vld_n2", 32'(bus.rd_valid), 1);
      chk("t1_dat",    32'(bus.rd_data), 32'h100);
      chk("t1_pkt",    32'(bus.pkt_cnt), 1);
      chk("t1_rlvl4",  32'(bus.rd_water_level), 4);
      chk("t1_ae",     32'(bus.almost_empty), 0);
      for (int i = 0; i < 4; i++) pop_chk("t1_pop", 16'(16'h100 + i), i == 3);
      bus.rd_en = 1'b0;
      chk("t1_pkt0",  32'(bus.pkt_cnt), 0);
      chk("t1_empty", 32'(bus.rd_empty), 1);

      // frames of 3, 1 and 5 words, then nine consecutive pops
      lens = '{3, 1, 5};
      k = 0;
      for (int f = 0; f < 3; f++) begin
         for (int w = 0; w < lens[f]; w++) begin
            wr_word(16'(16'h200 + k), w == lens[f] - 1);
            k++;
         end
      end
      wr_idle();
      repeat (3) cyc();
      chk("t2_pkt3", 32'(bus.pkt_cnt), 3);
      chk("t2_rlvl", 32'(bus.rd_water_level), 9);
      for (int j = 0; j < 9; j++) begin
         pop_chk("t2_pop", 16'(16'h200 + j), (j == 2) || (j == 3) || (j == 8));
         if (j == 2) chk("t2_pkt2", 32'(bus.pkt_cnt), 2);
         if (j == 3) chk("t2_pkt1", 32'(bus.pkt_cnt), 1);
         if (j == 8) chk("t2_pkt0", 32'(bus.pkt_cnt), 0);
      end
      bus.rd_en = 1'b0;
      chk("t2_empty", 32'(bus.rd_empty), 1);

      // 6 words then wr_drop together with wr_en
      for (int i = 0; i < 6; i++) wr_word(16'(16'h300 + i), 1'b0);
      chk("t3_wlvl6", 32'(bus.wr_water_level), 6);
      bus.wr_drop = 1'b1;
      wr_word(16'h3ff, 1'b0);
      wr_idle();
      chk("t3_wlvl0", 32'(bus.wr_water_level), 0);
      chk("t3_ovf",   32'(bus.wr_ovf_drop), 0);
      repeat (2) begin
         cyc();
         chk("t3_vld",  32'(bus.rd_valid), 0);
         chk("t3_rlvl", 32'(bus.rd_water_level), 0);
      end

      // commit 10 words, then a 10-word frame that overflows
      for (int i = 0; i < 10; i++) wr_word(16'(16'h400 + i), i == 9);
      chk("t4_wlvl10", 32'(bus.wr_water_level), 10);
      chk("t4_pkt1",   32'(bus.pkt_cnt), 1);
      for (int i = 0; i < 10; i++) begin
         wr_word(16'(16'h500 + i), i == 9);
         exp_lvl = (i < 6) ? 11 + i : ((i == 9) ? 10 : 16);
         chk("t4_wlvl", 32'(bus.wr_water_level), exp_lvl);
         chk("t4_full", 32'(bus.wr_full), 32'((i >= 5) && (i < 9)));
         chk("t4_ovf",  32'(bus.wr_ovf_drop), 32'(i == 9));
         chk("t4_af",   32'(bus.almost_full), 32'(exp_lvl >= 14));
      end
      wr_idle();
      cyc();
      chk("t4_ovf_end", 32'(bus.wr_ovf_drop), 0);
      chk("t4_wlvl_end", 32'(bus.wr_water_level), 10);
      chk("t4_pkt_end", 32'(bus.pkt_cnt), 1);
      for (int i = 0; i < 10; i++) begin
         pop_chk("t4_pop", 16'(16'h400 + i), i == 9);
         chk("t4_rlvl", 32'(bus.rd_water_level), 9 - i);
         chk("t4_ae",   32'(bus.almost_empty), 32'((9 - i) <= 2));
      end
      bus.rd_en = 1'b0;
      chk("t4_pkt0",  32'(bus.pkt_cnt), 0);
      chk("t4_empty", 32'(bus.rd_empty), 1);

      // final-word pop of A on the edge that C commits; B and C follow without a bubble
      wr_word(16'h600, 1'b0);
      wr_word(16'h601, 1'b1);
      wr_word(16'h610, 1'b0);
      wr_word(16'h611, 1'b1);
      wr_idle();
      repeat (3) cyc();
      chk("t5_pkt2", 32'(bus.pkt_cnt), 2);
      bus.wr_en   = 1'b1;
      bus.wr_data = 16'h620;
      bus.wr_last = 1'b0;
      pop_chk("t5_a0", 16'h600, 1'b0);
      chk("t5_pkt_a0", 32'(bus.pkt_cnt), 2);
      bus.wr_data = 16'h621;
      bus.wr_last = 1'b1;
      pop_chk("t5_a1", 16'h601, 1'b1);
      wr_idle();
      chk("t5_pkt_same", 32'(bus.pkt_cnt), 2);
      pop_chk("t5_b0", 16'h610, 1'b0);
      pop_chk("t5_b1", 16'h611, 1'b1);
      chk("t5_pkt_b", 32'(bus.pkt_cnt), 1);
      pop_chk("t5_c0", 16'h620, 1'b0);
      pop_chk("t5_c1", 16'h621, 1'b1);
      bus.rd_en = 1'b0;
      chk("t5_pkt_c", 32'(bus.pkt_cnt), 0);
      chk("t5_empty", 32'(bus.rd_empty), 1);

      // reset while a frame is open and a committed word is on the output
      wr_word(16'h700, 1'b1);
      wr_word(16'h710, 1'b0);
      wr_word(16'h711, 1'b0);
      chk("t6_vld_pre", 32'(bus.rd_valid), 1);
      chk("t6_pkt_pre", 32'(bus.pkt_cnt), 1);
      rst = 1'b1;
      wr_word(16'h712, 1'b0);
      chk_reset_vals("t6_rst");
      rst = 1'b0;
      wr_word(16'h800, 1'b1);
      wr_idle();
      repeat (2) cyc();
      chk("t6_vld",  32'(bus.rd_valid), 1);
      chk("t6_dat",  32'(bus.rd_data), 32'h800);
      chk("t6_last", 32'(bus.rd_last), 1);
      chk("t6_pkt",  32'(bus.pkt_cnt), 1);
      chk("t6_wlvl", 32'(bus.wr_water_level), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
